// File: rtl/risc_alu_pkg.sv
// Shared definitions for the RISC ALU datapath: opcode encodings, default
// widths, the registered flag bundle and the signed-overflow rule.
package risc_alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 16;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

  // Signed overflow: both addends share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_add_sub_add_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice; every carry is a flat
// sum-of-products of generate/propagate terms rather than a ripple chain.
module add_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic term;
    logic prop;
    c    = '0;
    term = 1'b0;
    prop = 1'b1;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = 1'b0;
      prop = 1'b1;
      // Walk down from bit i: a generate at j counts if every bit above it propagates.
      for (int j = i; j >= 0; j--) begin
        term = term | (g[j] & prop);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign s    = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one register stage per SLICE
// bits, whole-pipeline stall on output backpressure, flags registered with the result.
module pipelined_add_sub
  import risc_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SLICE;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result_reg;
  alu_flags_t       flags_reg;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (op_sub == OP_SUB) ? ~b : b;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * SLICE;
    localparam int REM = WIDTH - LO;

    // a_rem/b_rem: this stage's slice plus every slice still waiting above it.
    logic [REM-1:0]      a_rem;
    logic [REM-1:0]      b_rem;
    logic [LO+SLICE-1:0] sum_acc;
    logic [SLICE-1:0]    s;
    logic                cin;
    logic                cout;
    logic                vld_in;
    logic                vld_reg;

    add_slice #(
      .SLICE(SLICE)
    ) u_add_slice (
      .a   (a_rem[SLICE-1:0]),
      .b   (b_rem[SLICE-1:0]),
      .cin (cin),
      .s   (s),
      .cout(cout)
    );

    if (gi == 0) begin : g_src
      assign a_rem   = a;
      assign b_rem   = b_eff;
      assign cin     = op_sub;
      assign vld_in  = in_valid;
      assign sum_acc = s;
    end else begin : g_src
      assign a_rem   = g_stage[gi-1].g_skew.a_up_reg;
      assign b_rem   = g_stage[gi-1].g_skew.b_up_reg;
      assign cin     = g_stage[gi-1].g_skew.cout_reg;
      assign vld_in  = g_stage[gi-1].vld_reg;
      assign sum_acc = {s, g_stage[gi-1].g_skew.sum_reg};
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_reg <= 1'b0;
      end else if (adv) begin
        vld_reg <= vld_in;
      end
    end

    if (gi == STAGES - 1) begin : g_last
      // Bubbles load zeros so a stale or uninitialised sum never shows on the outputs.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          result_reg <= '0;
          flags_reg  <= '0;
        end else if (adv) begin
          if (vld_in) begin
            result_reg         <= sum_acc;
            flags_reg.carry    <= cout;
            flags_reg.overflow <= signed_ovf(a_rem[SLICE-1], b_rem[SLICE-1], s[SLICE-1]);
            flags_reg.zero     <= ~|sum_acc;
          end else begin
            result_reg <= '0;
            flags_reg  <= '0;
          end
        end
      end
    end else begin : g_skew
      localparam int UP = WIDTH - LO - SLICE;

      logic [UP-1:0]       a_up_reg;
      logic [UP-1:0]       b_up_reg;
      logic [LO+SLICE-1:0] sum_reg;
      logic                cout_reg;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_up_reg <= a_rem[REM-1:SLICE];
          b_up_reg <= b_rem[REM-1:SLICE];
          sum_reg  <= sum_acc;
          cout_reg <= cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_reg;
  assign result    = result_reg;
  assign carry     = flags_reg.carry;
  assign overflow  = flags_reg.overflow;
  assign zero      = flags_reg.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: a 2-stage (SLICE=16) and a 4-stage (SLICE=8)
// instance share stimulus; each is checked every cycle against a queue model.
module tb_pipelined_add_sub;
  import risc_alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    int           age;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready2, out_valid2, carry2, overflow2, zero2;
  logic [W-1:0] result2;
  logic         in_ready4, out_valid4, carry4, overflow4, zero4;
  logic [W-1:0] result4;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[2][$];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(W), .SLICE(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .carry(carry2), .overflow(overflow2), .zero(zero2)
  );

  pipelined_add_sub #(.WIDTH(W), .SLICE(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .carry(carry4), .overflow(overflow4), .zero(zero4)
  );

  // Reference arithmetic straight from the two's-complement definitions.
  function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    exp_t        e;
    logic [W:0]  full;
    if (sub) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else     full = {1'b0, x} + {1'b0, y};
    e.r   = full[W-1:0];
    e.c   = full[W];
    e.v   = sub ? ((x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]))
                : ((x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]));
    e.z   = (e.r == '0);
    e.age = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: each accepted beat ages by one on every advancing edge and is due at age == depth.
  task automatic check_dut(input int d, input int depth, input logic ir, input logic ov,
                           input logic [W-1:0] r, input logic c, input logic v, input logic z);
    logic  ev;
    logic  madv;
    exp_t  e;
    string tag;
    tag  = (d == 0) ? "s2" : "s4";
    ev   = (q[d].size() > 0) && (q[d][0].age == depth);
    madv = !ev || out_ready;
    chk({tag, ".out_valid"}, ov, ev);
    chk({tag, ".in_ready"}, ir, madv);
    if (ev) begin
      e = q[d][0];
      chk({tag, ".result"}, r, e.r);
      chk({tag, ".flags"}, {c, v, z}, {e.c, e.v, e.z});
    end
    if (madv) begin
      if (ev) void'(q[d].pop_front());
      for (int i = 0; i < q[d].size(); i++) q[d][i].age = q[d][i].age + 1;
      if (in_valid) begin
        e     = ref_op(a, b, op_sub);
        e.age = 1;
        q[d].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
    end else begin
      check_dut(0, 2, in_ready2, out_valid2, result2, carry2, overflow2, zero2);
      check_dut(1, 4, in_ready4, out_valid4, result4, carry4, overflow4, zero4);
    end
  end

  logic [W-1:0] dir_a  [7] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005,
                               32'h80000000, 32'h00FF00FF, 32'h00FFFFFF};
  logic [W-1:0] dir_b  [7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007,
                               32'h00000001, 32'h00FF00FF, 32'h00000001};
  logic         dir_op [7] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_ADD};
  logic [W-1:0] dir_r  [7] = '{32'h00010000, 32'h00000000, 32'h80000000, 32'hFFFFFFFE,
                               32'h7FFFFFFF, 32'h00000000, 32'h01000000};
  logic [2:0]   dir_f  [7] = '{3'b000, 3'b101, 3'b010, 3'b000, 3'b110, 3'b101, 3'b000};

  initial begin
    exp_t e;
    int   lat2;
    int   lat4;

    repeat (2) step();
    chk("reset.out_valid2", out_valid2, 1'b0);
    chk("reset.out_valid4", out_valid4, 1'b0);
    chk("reset.result2", result2, '0);
    chk("reset.flags2", {carry2, overflow2, zero2}, 3'b000);
    chk("reset.flags4", {carry4, overflow4, zero4}, 3'b000);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Directed vectors, back to back; model pinned against hand values first.
    for (int i = 0; i < 7; i++) begin
      e = ref_op(dir_a[i], dir_b[i], dir_op[i]);
      chk($sformatf("pin%0d.result", i), e.r, dir_r[i]);
      chk($sformatf("pin%0d.flags", i), {e.c, e.v, e.z}, dir_f[i]);
      a = dir_a[i]; b = dir_b[i]; op_sub = dir_op[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Latency of a single beat on an idle pipeline.
    a = 32'h0001_2345; b = 32'h0000_FFFF; op_sub = OP_ADD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat2 = 0;
    lat4 = 0;
    for (int n = 1; n <= 12; n++) begin
      if (out_valid2 && lat2 == 0) lat2 = n;
      if (out_valid4 && lat4 == 0) lat4 = n;
      if (lat2 != 0 && lat4 != 0) break;
      step();
    end
    chk("latency.s2", lat2, 2);
    chk("latency.s4", lat4, 4);
    repeat (4) step();

    // Ten back-to-back beats with no backpressure.
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; op_sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      chk("stream.in_ready2", in_ready2, 1'b1);
      chk("stream.in_ready4", in_ready4, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Backpressure: out_ready low for 3 cycles in the middle of a stream.
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; op_sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      out_ready = !(i >= 4 && i < 7);
      step();
    end

    // Random valid/ready traffic with random operands.
    for (int i = 0; i < 200; i++) begin
      a = $urandom; b = $urandom; op_sub = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) > 1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    chk("drain.pending2", q[0].size(), 0);
    chk("drain.pending4", q[1].size(), 0);

    // Reset with two beats in flight.
    a = 32'h0000_0003; b = 32'h0000_0004; op_sub = OP_ADD; in_valid = 1'b1;
    step();
    a = 32'hFFFF_0000; b = 32'h0001_0000; op_sub = OP_ADD;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset.out_valid2", out_valid2, 1'b0);
    chk("midreset.out_valid4", out_valid4, 1'b0);
    chk("midreset.result2", result2, '0);
    chk("midreset.flags2", {carry2, overflow2, zero2}, 3'b000);
    chk("midreset.flags4", {carry4, overflow4, zero4}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      chk("postreset.idle2", out_valid2, 1'b0);
      chk("postreset.idle4", out_valid4, 1'b0);
      step();
    end

    a = 32'h1234_5678; b = 32'h1111_1111; op_sub = OP_ADD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat2 = 0;
    for (int n = 1; n <= 12; n++) begin
      if (out_valid2) begin
        lat2 = n;
        break;
      end
      step();
    end
    chk("postreset.latency2", lat2, 2);
    chk("postreset.result2", result2, 32'h2345_6789);
    chk("postreset.flags2", {carry2, overflow2, zero2}, 3'b000);
    repeat (6) step();
    chk("final.pending2", q[0].size(), 0);
    chk("final.pending4", q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
